// File: rtl/traffic_pkg.sv
// Shared lamp encodings, FSM state type and default timing for the
// highway/city-road intersection controller.
package traffic_pkg;

  localparam logic [1:0] LAMP_RED    = 2'b00;
  localparam logic [1:0] LAMP_YELLOW = 2'b01;
  localparam logic [1:0] LAMP_GREEN  = 2'b10;

  typedef enum logic [1:0] {
    S_HG = 2'b00,
    S_HY = 2'b01,
    S_CG = 2'b10,
    S_CY = 2'b11
  } state_e;

  localparam int DEF_CAR_THRESH    = 5;
  localparam int DEF_MIN_HWY_GREEN = 4;
  localparam int DEF_YELLOW_CYCLES = 2;
  localparam int DEF_CITY_GREEN    = 5;
  localparam int DEF_TMR_W         = 4;

  typedef struct packed {
    logic [1:0] hwy;
    logic [1:0] city;
  } lamps_t;

  function automatic lamps_t make_lamps(input logic [1:0] hwy, input logic [1:0] city);
    lamps_t l;
    l.hwy  = hwy;
    l.city = city;
    return l;
  endfunction

endpackage

// File: rtl/traffic_dwell_timer.sv
// Saturating cycle counter for the time spent in the current FSM state;
// clear wins over enable so the count restarts at 0 on a state change.
module traffic_dwell_timer #(
  parameter int TMR_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [TMR_W-1:0] count_o
);

  logic [TMR_W-1:0] count_q;
  logic [TMR_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && (count_q != {TMR_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/mealy_traffic_fsm.sv
// Mealy highway/city-road light controller. Optional macro CITY_GAPOUT_EN
// lets an empty city road cut city green short.
module mealy_traffic_fsm #(
  parameter int CAR_THRESH    = 5,
  parameter int MIN_HWY_GREEN = 4,
  parameter int YELLOW_CYCLES = 2,
  parameter int CITY_GREEN    = 5,
  parameter int TMR_W         = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] carCount,
  output logic [1:0] Highway,
  output logic [1:0] Cityroad
);

  import traffic_pkg::*;

  // Timer value seen during the final cycle of each dwell.
  localparam logic [TMR_W-1:0] HG_LAST = TMR_W'(MIN_HWY_GREEN - 1);
  localparam logic [TMR_W-1:0] Y_LAST  = TMR_W'(YELLOW_CYCLES - 1);
  localparam logic [TMR_W-1:0] CG_LAST = TMR_W'(CITY_GREEN - 1);
  localparam logic [2:0]       THRESH  = 3'(CAR_THRESH);
`ifdef CITY_GAPOUT_EN
  localparam logic [TMR_W-1:0] GAP_MIN = TMR_W'(1);
`endif

  state_e           state_q;
  state_e           state_d;
  logic [TMR_W-1:0] timer;
  logic             go;
  logic             cg_end;
  lamps_t           lamps;

  traffic_dwell_timer #(
    .TMR_W (TMR_W)
  ) u_timer (
    .clk_i   (clock),
    .rst_i   (reset),
    .clear_i (state_d != state_q),
    .en_i    (1'b1),
    .count_o (timer)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_HG;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    go      = 1'b0;
    cg_end  = 1'b0;
    lamps   = make_lamps(LAMP_GREEN, LAMP_RED);
    case (state_q)
      S_HG: begin
        go = (timer >= HG_LAST) && (carCount >= THRESH);
        if (go) begin
          lamps.hwy = LAMP_YELLOW;
          state_d   = S_HY;
        end
      end
      S_HY: begin
        lamps = make_lamps(LAMP_YELLOW, LAMP_RED);
        if (timer >= Y_LAST) begin
          state_d = S_CG;
        end
      end
      S_CG: begin
        lamps  = make_lamps(LAMP_RED, LAMP_GREEN);
        cg_end = (timer >= CG_LAST);
`ifdef CITY_GAPOUT_EN
        cg_end = cg_end || ((carCount == 3'd0) && (timer >= GAP_MIN));
`endif
        if (cg_end) begin
          lamps.city = LAMP_YELLOW;
          state_d    = S_CY;
        end
      end
      S_CY: begin
        lamps = make_lamps(LAMP_RED, LAMP_YELLOW);
        if (timer >= Y_LAST) begin
          state_d = S_HG;
        end
      end
      default: begin
        state_d = S_HG;
      end
    endcase
    // Hold the idle lamp pattern for as long as reset is asserted.
    if (reset) begin
      lamps = make_lamps(LAMP_GREEN, LAMP_RED);
    end
  end

  assign Highway  = lamps.hwy;
  assign Cityroad = lamps.city;

endmodule

// File: tb/tb_mealy_traffic_fsm.sv
// Directed bench for mealy_traffic_fsm: a per-cycle vector table plus
// hand-written sequences for steady traffic, async reset and city gap-out.
module tb_mealy_traffic_fsm;

  localparam logic [1:0] R = 2'b00;
  localparam logic [1:0] Y = 2'b01;
  localparam logic [1:0] G = 2'b10;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] carCount = 3'd0;
  logic [1:0] Highway;
  logic [1:0] Cityroad;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic       rst;
    logic [2:0] cc;
    logic [1:0] eh;
    logic [1:0] ec;
  } vec_t;

  vec_t vecs[$];

  mealy_traffic_fsm dut (
    .clock    (clock),
    .reset    (reset),
    .carCount (carCount),
    .Highway  (Highway),
    .Cityroad (Cityroad)
  );

  always #5 clock = ~clock;

  function automatic void add(input logic r, input logic [2:0] c,
                              input logic [1:0] h, input logic [1:0] cy, input int n);
    vec_t v;
    v.rst = r;
    v.cc  = c;
    v.eh  = h;
    v.ec  = cy;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [1:0] eh, input logic [1:0] ec);
    tests_run++;
    if ({Highway, Cityroad} !== {eh, ec}) begin
      tests_failed++;
      $display("FAIL %s: Highway=%b Cityroad=%b, required Highway=%b Cityroad=%b",
               name, Highway, Cityroad, eh, ec);
    end else begin
      $display("[TB] %s carCount=%0d reset=%b Highway=%b Cityroad=%b ok",
               name, carCount, reset, Highway, Cityroad);
    end
    tests_run++;
    if ((Highway !== R) && (Cityroad !== R)) begin
      tests_failed++;
      $display("FAIL %s_one_red: Highway=%b Cityroad=%b, required at least one RED",
               name, Highway, Cityroad);
    end
  endtask

  task automatic step(input string name, input logic r, input logic [2:0] c,
                      input logic [1:0] eh, input logic [1:0] ec);
    @(negedge clock);
    reset    = r;
    carCount = c;
    #1;
    check(name, eh, ec);
  endtask

  function automatic void steady_expect(input int phase, output logic [1:0] h, output logic [1:0] c);
    if (phase <= 2)       begin h = G; c = R; end
    else if (phase <= 5)  begin h = Y; c = R; end
    else if (phase <= 9)  begin h = R; c = G; end
    else                  begin h = R; c = Y; end
  endfunction

  initial begin
    logic [1:0] eh;
    logic [1:0] ec;

    // Reset, idle, low traffic.
    add(1, 3'd0, G, R, 2);
    add(0, 3'd0, G, R, 2);
    add(0, 3'd2, G, R, 10);
    // Long-waiting request: Mealy yellow, then full cycle.
    add(0, 3'd5, Y, R, 1);
    add(0, 3'd5, Y, R, 2);
    add(0, 3'd5, R, G, 4);
    add(0, 3'd5, R, Y, 1);
    add(0, 3'd5, R, Y, 2);
    // Request from HG entry: honoured at the 4th HG cycle; drop during cycle.
    add(0, 3'd5, G, R, 3);
    add(0, 3'd5, Y, R, 1);
    add(0, 3'd1, Y, R, 2);
    add(0, 3'd1, R, G, 4);
    add(0, 3'd1, R, Y, 1);
    add(0, 3'd1, R, Y, 2);
    // Threshold boundary: 4 never triggers, 6 does.
    add(0, 3'd4, G, R, 6);
    add(0, 3'd6, Y, R, 1);
    add(0, 3'd1, Y, R, 2);
    add(0, 3'd1, R, G, 4);
    add(0, 3'd1, R, Y, 1);
    add(0, 3'd1, R, Y, 2);
    // Request dropped before go is forgotten.
    add(0, 3'd5, G, R, 2);
    add(0, 3'd0, G, R, 3);
    add(0, 3'd7, Y, R, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].cc, vecs[i].eh, vecs[i].ec);
    end

    // carCount=7 held: 13-cycle period, entered one cycle after go (phase 4).
    for (int i = 0; i < 39; i++) begin
      steady_expect((i + 4) % 13, eh, ec);
      step($sformatf("steady%0d", i), 1'b0, 3'd7, eh, ec);
    end

    // Asynchronous reset in the middle of city green.
    step("rst_hy0", 1'b0, 3'd3, Y, R);
    step("rst_hy1", 1'b0, 3'd3, Y, R);
    step("rst_cg0", 1'b0, 3'd3, R, G);
    step("rst_cg1", 1'b0, 3'd3, R, G);
    reset = 1'b1;
    #1;
    check("rst_async", G, R);
    step("rst_hold", 1'b1, 3'd3, G, R);
    step("rst_hg0", 1'b0, 3'd5, G, R);
    step("rst_hg1", 1'b0, 3'd5, G, R);
    step("rst_hg2", 1'b0, 3'd5, G, R);
    step("rst_hg3", 1'b0, 3'd5, Y, R);

    // Empty city road during city green.
    step("gap_hy0", 1'b0, 3'd0, Y, R);
    step("gap_hy1", 1'b0, 3'd0, Y, R);
    step("gap_cg0", 1'b0, 3'd0, R, G);
`ifdef CITY_GAPOUT_EN
    step("gap_cg1", 1'b0, 3'd0, R, Y);
`else
    step("gap_cg1", 1'b0, 3'd0, R, G);
    step("gap_cg2", 1'b0, 3'd0, R, G);
    step("gap_cg3", 1'b0, 3'd0, R, G);
    step("gap_cg4", 1'b0, 3'd0, R, Y);
`endif
    step("gap_cy0", 1'b0, 3'd0, R, Y);
    step("gap_cy1", 1'b0, 3'd0, R, Y);
    step("gap_hg0", 1'b0, 3'd0, G, R);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
